mmm_compute_ctrl: RTL and testbench
===================================

MMM_COMPUTE_CTRL -- requirements
Module: mmm_compute_ctrl

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: M, 7, rows of A/C; N, 9, columns of B/C; MAXK, 8, max inner dimension; MAC_LAT, 1, cycles from last mac_en to MAC result valid (>=1); FIFO_DEPTH, 16, output FIFO entries.
REQ-002 Derived widths SHALL be: K_BITS=$clog2(MAXK+1), A_ADDR_BITS=$clog2(M*MAXK), B_ADDR_BITS=$clog2(MAXK*N), F_BITS=$clog2(FIFO_DEPTH+1).
REQ-003 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 matrices_loaded  input  1  A and B memories hold valid operands.
REQ-006 K  input  K_BITS  inner dimension; stable while matrices_loaded=1.
REQ-007 A_read_addr  output  A_ADDR_BITS  A address, row-major m*K+k.
REQ-008 B_read_addr  output  B_ADDR_BITS  B address, n*K+k.
REQ-009 mac_en  output  1  memory data for one product valid this cycle.
REQ-010 mac_init  output  1  with mac_en: first term of a dot product (accumulator load, not add).
REQ-011 result_valid  output  1  one C element valid at MAC output this cycle.
REQ-012 fifo_free  input  F_BITS  free entries in output FIFO.
REQ-013 compute_finished  output  1  one-cycle pulse: all M*N results delivered.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE->ISSUE when matrices_loaded=1 and K!=0; IDLE->DONE when matrices_loaded=1 and K=0 (no results, no mac_en).
REQ-016 Element order SHALL be m outer, n middle, k inner; C(m,n) emitted in order m*N+n.
REQ-017 In ISSUE, a dot product SHALL start (k=0 issued) only if fifo_free > inflight, inflight = started dot products whose result_valid has not yet occurred; otherwise addresses hold, no issue.
REQ-018 Once started, a dot product SHALL issue k=0..K-1 on K consecutive cycles without stall.
REQ-019 Addresses SHALL be generated incrementally (a_base+=K per m, b_base+=K per n, b_base->0 on n wrap); no multipliers.
REQ-020 Memory read latency is 1: mac_en (and mac_init for k=0) SHALL assert the cycle after the corresponding issue.
REQ-021 result_valid SHALL assert exactly MAC_LAT cycles after the mac_en of k=K-1.
REQ-022 inflight SHALL increment on dot-product start, decrement on result_valid, both in one cycle -> unchanged.
REQ-023 ISSUE->DRAIN after issuing k=K-1 of element (M-1,N-1); DRAIN->DONE in cycle after final result_valid; DONE->IDLE after one cycle.
REQ-024 compute_finished SHALL be 1 only in DONE.
REQ-025 Outside ISSUE, A_read_addr/B_read_addr SHALL be 0.
REQ-026 matrices_loaded falling during ISSUE/DRAIN SHALL be ignored; sequence completes.

Reset
REQ-027 Reset SHALL force IDLE, clear all counters, inflight, and pipeline valid bits; all outputs 0 next cycle, including mid-operation; in-flight results are discarded (no result_valid).

Structure
REQ-028 Package mmm_pkg SHALL hold the state enum type and width functions shared with input_mems.
REQ-029 One sub-module mmm_valid_pipe (parameterized depth single-bit delay line) SHALL generate result_valid from last-term strobes.

Verification
REQ-030 M=2,N=2,K=3,MAC_LAT=1,fifo_free=16: ISSUE entered cycle 0 -> issues cycles 0-11, mac_init at 1,4,7,10, result_valid at 4,7,10,13, compute_finished at 14.
REQ-031 Same config -> A_read_addr sequence 0,1,2,0,1,2,3,4,5,3,4,5; B_read_addr 0,1,2,3,4,5,0,1,2,3,4,5.
REQ-032 fifo_free=0 for 5 cycles after matrices_loaded, then 16 -> no mac_en during hold, first issue cycle after release, results unchanged.
REQ-033 fifo_free=1 constant, MAC_LAT=3, K=2 -> inflight never exceeds 1; next start only the cycle after each result_valid.
REQ-034 K=0 with matrices_loaded=1 -> compute_finished next cycle, no mac_en/result_valid.
REQ-035 Reset asserted mid-ISSUE at element (0,1) -> all outputs 0 next cycle, no further result_valid; new matrices_loaded restarts from (0,0).

Source files
------------

// File: rtl/mmm_compute_ctrl_pkg.sv
// Shared types and width helpers for the matrix-multiply compute controller
// and the operand memories it addresses.
package mmm_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} mmm_state_e;

  function automatic int k_bits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int a_addr_bits(input int m, input int maxk);
    return $clog2(m * maxk);
  endfunction

  function automatic int b_addr_bits(input int maxk, input int n);
    return $clog2(maxk * n);
  endfunction

  function automatic int f_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmm_compute_ctrl_if.sv
// Control/address bundle between the sequencer (slave side here) and the
// surrounding memories, MAC and output FIFO.
interface mmm_compute_ctrl_if import mmm_pkg::*; #(
    parameter int M          = 7,
    parameter int N          = 9,
    parameter int MAXK       = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int K_BITS      = k_bits(MAXK);
    localparam int A_ADDR_BITS = a_addr_bits(M, MAXK);
    localparam int B_ADDR_BITS = b_addr_bits(MAXK, N);
    localparam int F_BITS      = f_bits(FIFO_DEPTH);

    logic                   matrices_loaded;
    logic [K_BITS-1:0]      K;
    logic [F_BITS-1:0]      fifo_free;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic                   mac_en;
    logic                   mac_init;
    logic                   result_valid;
    logic                   compute_finished;

    modport master (
        output matrices_loaded, K, fifo_free,
        input  A_read_addr, B_read_addr, mac_en, mac_init, result_valid, compute_finished
    );

    modport slave (
        input  matrices_loaded, K, fifo_free,
        output A_read_addr, B_read_addr, mac_en, mac_init, result_valid, compute_finished
    );
endinterface

// File: rtl/mmm_compute_ctrl_valid_pipe.sv
// Single-bit delay line: dout follows din by STAGES+1 cycles.
module mmm_valid_pipe #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic [STAGES:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:0], din};
    end

    assign dout = vld_pipe[STAGES];
endmodule

// File: rtl/mmm_compute_ctrl.sv
// Sequences C = A*B dot products: issues operand addresses m/n/k, strobes the
// MAC, and throttles dot-product starts against free output-FIFO space.
module mmm_compute_ctrl import mmm_pkg::*; #(
    parameter int M          = 7,
    parameter int N          = 9,
    parameter int MAXK       = 8,
    parameter int MAC_LAT    = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    mmm_compute_ctrl_if.slave  bus
);
    localparam int K_BITS      = k_bits(MAXK);
    localparam int A_ADDR_BITS = a_addr_bits(M, MAXK);
    localparam int B_ADDR_BITS = b_addr_bits(MAXK, N);
    localparam int F_BITS      = f_bits(FIFO_DEPTH);
    localparam int M_BITS      = cnt_bits(M);
    localparam int N_BITS      = cnt_bits(N);

    mmm_state_e             state, state_nxt;
    logic [K_BITS-1:0]      k_len, k_cnt;
    logic [M_BITS-1:0]      m_cnt;
    logic [N_BITS-1:0]      n_cnt;
    logic [A_ADDR_BITS-1:0] a_base;
    logic [B_ADDR_BITS-1:0] b_base;
    logic [F_BITS-1:0]      inflight;
    logic                   mac_en_q, mac_init_q;
    logic                   start, issue, k_last, last_elem, result_valid;

    always_comb begin
        k_last    = (k_cnt == k_len - K_BITS'(1));
        last_elem = (m_cnt == M_BITS'(M - 1)) && (n_cnt == N_BITS'(N - 1));
        // A new dot product only begins when its result is guaranteed a FIFO slot.
        start     = (state == ISSUE) && (k_cnt == '0) && (bus.fifo_free > inflight);
        issue     = start || ((state == ISSUE) && (k_cnt != '0));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.matrices_loaded) state_nxt = (bus.K == '0) ? DONE : ISSUE;
            ISSUE: if (issue && k_last && last_elem) state_nxt = DRAIN;
            DRAIN: if (result_valid && inflight == F_BITS'(1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_len      <= '0;
            k_cnt      <= '0;
            m_cnt      <= '0;
            n_cnt      <= '0;
            a_base     <= '0;
            b_base     <= '0;
            inflight   <= '0;
            mac_en_q   <= 1'b0;
            mac_init_q <= 1'b0;
        end else begin
            mac_en_q   <= issue;
            mac_init_q <= issue && (k_cnt == '0);

            if (start && !result_valid)      inflight <= inflight + F_BITS'(1);
            else if (!start && result_valid) inflight <= inflight - F_BITS'(1);

            // K is captured here so a late change after matrices_loaded drops is harmless.
            if (state == IDLE) begin
                k_len  <= bus.K;
                k_cnt  <= '0;
                m_cnt  <= '0;
                n_cnt  <= '0;
                a_base <= '0;
                b_base <= '0;
            end else if (issue) begin
                if (k_last) begin
                    k_cnt <= '0;
                    if (n_cnt == N_BITS'(N - 1)) begin
                        n_cnt  <= '0;
                        b_base <= '0;
                        m_cnt  <= m_cnt + M_BITS'(1);
                        a_base <= a_base + A_ADDR_BITS'(k_len);
                    end else begin
                        n_cnt  <= n_cnt + N_BITS'(1);
                        b_base <= b_base + B_ADDR_BITS'(k_len);
                    end
                end else begin
                    k_cnt <= k_cnt + K_BITS'(1);
                end
            end
        end
    end

    // Last-term issue -> one cycle memory read -> MAC_LAT cycles of MAC.
    mmm_valid_pipe #(.STAGES(MAC_LAT)) u_valid_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (issue && k_last),
        .dout  (result_valid)
    );

    assign bus.A_read_addr      = (state == ISSUE) ? a_base + A_ADDR_BITS'(k_cnt) : '0;
    assign bus.B_read_addr      = (state == ISSUE) ? b_base + B_ADDR_BITS'(k_cnt) : '0;
    assign bus.mac_en           = mac_en_q;
    assign bus.mac_init         = mac_init_q;
    assign bus.result_valid     = result_valid;
    assign bus.compute_finished = (state == DONE);
endmodule

// File: tb/tb_mmm_compute_ctrl.sv
// Randomized scoreboard bench for mmm_compute_ctrl: expected MAC transactions
// are queued per run; a negedge monitor checks addresses, flow control and timing.
module tb_mmm_compute_ctrl;
    import mmm_pkg::*;

    localparam int M          = 2;
    localparam int N          = 3;
    localparam int MAXK       = 8;
    localparam int MAC_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int F_BITS     = f_bits(FIFO_DEPTH);
    localparam int K_BITS     = k_bits(MAXK);

    typedef struct {
        int a;
        int b;
        int k;
        bit last;
        bit fin;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmm_compute_ctrl_if #(.M(M), .N(N), .MAXK(MAXK), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    mmm_compute_ctrl #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(MAC_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    item_t exp_q[$];
    int    res_q[$];
    int    checks = 0, errors = 0;
    int    cyc = 0;
    int    ff_mode = 0;
    bit    run_active = 0, issue_done = 0;
    int    run_k = 0, issue_entry = 0;
    int    inits_total = 0, results_total = 0, last_res_cyc = -10;
    int    a_prev = 0, b_prev = 0, ff_prev = 0, infl_prev = 0;
    bit    prev_mac_en = 0, opp_prev = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ff_mode)
            0:       bus.fifo_free = F_BITS'(FIFO_DEPTH);
            1:       bus.fifo_free = F_BITS'($urandom_range(0, FIFO_DEPTH));
            2:       bus.fifo_free = F_BITS'(1);
            default: bus.fifo_free = '0;
        endcase
    end

    // Monitor: cycle t sees mac_en(t) as the consequence of the issue decision at t-1.
    always @(negedge clk) begin
        bit    cur_mid, exp_start, exp_fin, in_issue;
        int    infl_cur;
        item_t it;
        if (!reset) begin
            cur_mid = 0;
            if (run_active) begin
                exp_start = opp_prev && (ff_prev > infl_prev);
                chk("start_decision", int'(bus.mac_init), int'(exp_start));
            end
            chk("init_without_en", int'(bus.mac_init & ~bus.mac_en), 0);
            if (bus.mac_en) begin
                if (exp_q.size() == 0) chk("mac_en_unexpected", int'(bus.mac_en), 0);
                else begin
                    it = exp_q.pop_front();
                    chk("a_addr", a_prev, it.a);
                    chk("b_addr", b_prev, it.b);
                    chk("mac_init", int'(bus.mac_init), int'(it.k == 0));
                    if (it.k != 0) chk("no_stall_in_dot", int'(prev_mac_en), 1);
                    if (it.last) res_q.push_back(cyc + MAC_LAT);
                    if (it.fin) issue_done = 1;
                    cur_mid = !it.last;
                end
            end
            if (bus.mac_init) inits_total++;
            infl_cur = inits_total - results_total;
            if (bus.result_valid) begin
                if (res_q.size() == 0) chk("result_unexpected", int'(bus.result_valid), 0);
                else chk("result_cycle", cyc, res_q.pop_front());
                results_total++;
                last_res_cyc = cyc;
            end
            if (run_active) begin
                exp_fin = (run_k == 0) ? (cyc == issue_entry)
                                       : (results_total == M * N && last_res_cyc == cyc - 1);
                chk("compute_finished", int'(bus.compute_finished), int'(exp_fin));
            end else begin
                chk("finished_idle", int'(bus.compute_finished), 0);
            end
            in_issue = run_active && cyc >= issue_entry && !issue_done;
            if (!in_issue) begin
                chk("a_addr_zero", int'(bus.A_read_addr), 0);
                chk("b_addr_zero", int'(bus.B_read_addr), 0);
            end
            if (run_active && bus.compute_finished) run_active = 0;
            opp_prev    = in_issue && !cur_mid && inits_total < M * N;
            ff_prev     = int'(bus.fifo_free);
            infl_prev   = infl_cur;
            a_prev      = int'(bus.A_read_addr);
            b_prev      = int'(bus.B_read_addr);
            prev_mac_en = bus.mac_en;
        end
    end

    task automatic start_run(input int k, input int mode);
        @(posedge clk); #1;
        exp_q.delete();
        res_q.delete();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                for (int kk = 0; kk < k; kk++)
                    exp_q.push_back('{m * k + kk, n * k + kk, kk, kk == k - 1,
                                      (m == M - 1) && (n == N - 1) && (kk == k - 1)});
        run_k = k;
        issue_entry = cyc + 1;
        issue_done = (k == 0);
        inits_total = 0;
        results_total = 0;
        last_res_cyc = -10;
        run_active = 1;
        ff_mode = mode;
        bus.K = K_BITS'(k);
        bus.matrices_loaded = 1'b1;
        // Dropping the load flag right after ISSUE is entered must not disturb the run.
        @(posedge clk); #1;
        bus.matrices_loaded = 1'b0;
        bus.K = K_BITS'($urandom_range(0, MAXK));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (run_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", int'(run_active), 0);
        run_active = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mac_en"},   int'(bus.mac_en), 0);
        chk({tag, "_mac_init"}, int'(bus.mac_init), 0);
        chk({tag, "_result"},   int'(bus.result_valid), 0);
        chk({tag, "_finished"}, int'(bus.compute_finished), 0);
        chk({tag, "_a_addr"},   int'(bus.A_read_addr), 0);
        chk({tag, "_b_addr"},   int'(bus.B_read_addr), 0);
    endtask

    initial begin
        int n;
        bus.matrices_loaded = 1'b0;
        bus.K = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        start_run(3, 0);      wait_idle(500);
        start_run(0, 0);      wait_idle(50);
        start_run(1, 0);      wait_idle(500);
        start_run(MAXK, 3);
        repeat (4) @(posedge clk);
        #1 ff_mode = 0;
        wait_idle(500);
        start_run(2, 2);      wait_idle(500);
        for (int r = 0; r < 6; r++) begin
            start_run($urandom_range(1, MAXK), 1);
            wait_idle(2000);
        end

        // Abort in the middle of element (0,1), then rerun from (0,0).
        start_run(3, 0);
        n = 0;
        while (inits_total < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_elem_0_1", int'(inits_total >= 2), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_active = 0;
        exp_q.delete();
        res_q.delete();
        prev_mac_en = 0;
        opp_prev = 0;
        @(negedge clk);
        check_outputs_zero("midrun_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (MAC_LAT + 4) @(posedge clk);
        start_run(3, 0);      wait_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
